// File: rtl/sbox_bram_reader_if.sv
// Bundle between the S-box BRAM read initiator and its neighbours: request
// side, BRAM ports A/B, and result side.
interface sbox_bram_reader_if #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_addr_a;
  logic [AW-1:0]    in_addr_b;
  logic [TAG_W-1:0] in_tag;
  logic [AW-1:0]    bram_addra;
  logic [AW-1:0]    bram_addrb;
  logic             bram_en;
  logic             bram_rst;
  logic [DW-1:0]    bram_doa;
  logic [DW-1:0]    bram_dob;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_a;
  logic [DW-1:0]    out_b;
  logic [TAG_W-1:0] out_tag;

  modport master (
    input  in_valid, in_addr_a, in_addr_b, in_tag, bram_doa, bram_dob, out_ready,
    output in_ready, bram_addra, bram_addrb, bram_en, bram_rst,
           out_valid, out_a, out_b, out_tag
  );

  modport slave (
    output in_valid, in_addr_a, in_addr_b, in_tag, bram_doa, bram_dob, out_ready,
    input  in_ready, bram_addra, bram_addrb, bram_en, bram_rst,
           out_valid, out_a, out_b, out_tag
  );
endinterface

// File: rtl/sbox_bram_reader.sv
// Dual-port S-box BRAM read initiator: 2-edge latency valid pipeline feeding a
// credit-protected FWFT result FIFO. Optional counters: SBOX_BRAM_READER_STATS_EN.
module sbox_bram_reader #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sbox_bram_reader_if.master bus
`ifdef SBOX_BRAM_READER_STATS_EN
  ,
  output logic [31:0]        stat_lookups,
  output logic [31:0]        stat_stalls
`endif
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned CW = OW + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    b;
    logic [DW-1:0]    a;
  } entry_t;

  logic             r_v1;
  logic             r_v2;
  logic [TAG_W-1:0] r_t1;
  logic [TAG_W-1:0] r_t2;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  entry_t           r_mem [DEPTH];

  logic             w_in_ready;
  logic             w_accept;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  entry_t           w_head;

  // Credit covers buffered entries plus both in-flight pipeline stages
  assign w_in_ready = rst && ((CW'(r_occ) + CW'(r_v1) + CW'(r_v2)) < CW'(DEPTH));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_empty    = (r_occ == '0);
  assign w_push     = r_v2;
  assign w_pop      = bus.out_ready && !w_empty;
  assign w_wr_nxt   = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_nxt   = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign w_head     = r_mem[r_rd_ptr];

  assign bus.in_ready   = w_in_ready;
  assign bus.bram_addra = rst ? bus.in_addr_a : '0;
  assign bus.bram_addrb = rst ? bus.in_addr_b : '0;
  assign bus.bram_en    = w_accept || r_v1;
  assign bus.bram_rst   = 1'b0;
  assign bus.out_valid  = !w_empty;
  assign bus.out_a      = w_empty ? '0 : w_head.a;
  assign bus.out_b      = w_empty ? '0 : w_head.b;
  assign bus.out_tag    = w_empty ? '0 : w_head.tag;

  // Latency pipeline and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_t1     <= '0;
      r_t2     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      if (w_accept) r_t1 <= bus.in_tag;
      if (r_v1)     r_t2 <= r_t1;
      if (w_push)   r_wr_ptr <= w_wr_nxt;
      if (w_pop)    r_rd_ptr <= w_rd_nxt;
      if (w_push && !w_pop)      r_occ <= r_occ + OW'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - OW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted in r_occ
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{tag: r_t2, b: bus.bram_dob, a: bus.bram_doa};
  end

`ifdef SBOX_BRAM_READER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups <= '0;
      stat_stalls  <= '0;
    end else begin
      if (w_accept)                    stat_lookups <= stat_lookups + 32'd1;
      if (bus.in_valid && !w_in_ready) stat_stalls  <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sbox_bram_reader.md
Name: sbox_bram_reader

Overview:
- Read-side initiator for the masked S-box lookup BRAMs, i.e. the dual-port 10-bit-address, 8-bit-data tables with output register enabled (2-edge read latency, shared EN/REGCE).
- Accepts address pairs from the share logic with a valid/ready handshake and drives ports A and B together.
- Tracks the fixed BRAM latency with a valid pipeline.
- Buffers returned byte pairs in a credit-protected output FIFO, so downstream backpressure never stalls the BRAM mid-read.

Parameters:
- AW, 10: BRAM address width per port.
- DW, 8: BRAM data width per port.
- TAG_W, 4: sideband tag width carried alongside each lookup (e.g. byte index).
- DEPTH, 4: output FIFO entries; legal range 3..16; full throughput requires DEPTH >= 4.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: lookup request valid.
- in_ready, output, 1: request accepted when in_valid && in_ready at a rising edge.
- in_addr_a, input, AW: port-A table address.
- in_addr_b, input, AW: port-B table address.
- in_tag, input, TAG_W: sideband returned with the result.
- bram_addra, output, AW: to BRAM ADDRA.
- bram_addrb, output, AW: to BRAM ADDRB.
- bram_en, output, 1: to BRAM EN (drives ENA/ENB/REGCEA/REGCEB).
- bram_rst, output, 1: to BRAM rst; constant 0.
- bram_doa, input, DW: from BRAM DOA.
- bram_dob, input, DW: from BRAM DOB.
- out_valid, output, 1: result available.
- out_ready, input, 1: result consumed when out_valid && out_ready at a rising edge.
- out_a, output, DW: port-A byte.
- out_b, output, DW: port-B byte.
- out_tag, output, TAG_W: tag of the result.

Behaviour:
- Reset (rst low, asynchronous): v1, v2, FIFO pointers and occupancy cleared. Outputs: in_ready=0 while rst low, out_valid=0, out_a=out_b=0, out_tag=0. bram_en=0, bram_addra/b=0.
- Reset released mid-operation: all in-flight lookups and buffered results are discarded. BRAM output register contents are ignored because v2=0.
- Address path is combinational pass-through: bram_addra=in_addr_a, bram_addrb=in_addr_b. Both ports are always driven in the same cycle.
- accept = in_valid && in_ready.
- in_ready = (occ + v1 + v2) < DEPTH. This is conservative: a same-cycle FIFO read is not credited.
- bram_en = accept || v1.
  - EN high at the accept edge latches the address.
  - EN high at the following edge loads the output register.
  - bram_en is low otherwise.
- Valid pipeline:
  - v1 <= accept; v2 <= v1.
  - Tag pipeline: t1 <= in_tag on accept; t2 <= t1 when v1.
- Capture: while v2=1, bram_doa, bram_dob and t2 are written into the FIFO at the next rising edge.
- Latency: request accepted at edge E0 gives data on DOA/DOB during the cycle after E1, written at E2. out_valid rises after E2, so 3 clocks accept-to-out_valid with an empty FIFO.
- Throughput: one lookup per clock when out_ready is held high and DEPTH >= 4.
- FIFO behaviour:
  - First-word fall-through.
  - out_valid = (occ != 0); out_a/out_b/out_tag = head entry.
  - Simultaneous write and read leaves occ unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the credit rule.
  - A read when empty is ignored.
- Ordering: results emerge strictly in acceptance order.
- Output stability: out_* hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: SBOX_BRAM_READER_STATS_EN.
- When defined, adds output ports:
  - stat_lookups (32 bits): accepted requests.
  - stat_stalls (32 bits): cycles with in_valid && !in_ready.
  - Both counters are reset by rst and wrap at 2^32.
- When undefined, the ports and counters are absent. Functional behaviour is identical either way.

Test Plan:
- Reset then single request in_addr_a=0x000, in_addr_b=0x001, tag=3, out_ready=1 -> bram_en high exactly 2 cycles. out_valid rises 3 clocks after accept with out_a/out_b equal to the BRAM model contents at 0x000/0x001 and out_tag=3.
- Back-to-back stream of 16 requests (addresses 0x100..0x10F on A, 0x30F..0x300 on B), out_ready=1, DEPTH=4 -> in_ready never drops. 16 results arrive on consecutive cycles in order.
- out_ready=0 with continuous in_valid -> exactly DEPTH lookups accepted, then in_ready=0. out_valid=1 with the first result held stable. Raising out_ready drains the results in order and in_ready returns.
- Toggle out_ready every other cycle for 50 random requests -> no loss, duplication or reordering versus the scoreboard. occ never exceeds DEPTH.
- Assert rst low while 2 requests are in flight and 2 are buffered -> out_valid=0 and in_ready=0 immediately. After release, no stale results appear and a new request returns correct data.
- With SBOX_BRAM_READER_STATS_EN defined, run the out_ready=0 fill scenario holding in_valid for 10 cycles -> stat_lookups=4 and stat_stalls=6.
